// File: rtl/frogg_button_arbiter_if.sv
// frogg_button_arbiter_if: raw switch inputs and arbitrated direction outputs
interface frogg_button_arbiter_if;
   logic       switch_up, switch_dn, switch_lt, switch_rt;
   logic       paddle_up, paddle_dn, paddle_lt, paddle_rt;
   logic [1:0] dir;
   logic       press_pulse;
   modport master(output switch_up, switch_dn, switch_lt, switch_rt,
                  input  paddle_up, paddle_dn, paddle_lt, paddle_rt, dir, press_pulse);
   modport slave (input  switch_up, switch_dn, switch_lt, switch_rt,
                  output paddle_up, paddle_dn, paddle_lt, paddle_rt, dir, press_pulse);
endinterface

// File: rtl/frogg_button_arbiter.sv
// frogg_button_arbiter: sync, debounce and one-hot arbitrate four direction switches
module frogg_button_arbiter #(
   parameter int c_DEBOUNCE_LIMIT = 250000
) (
   input logic                   i_Clk,
   input logic                   i_Rst,
   frogg_button_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, GRANT, WAIT_RELEASE} state_t;
   localparam logic [19:0] c_LAST = 20'(c_DEBOUNCE_LIMIT - 1);
   logic [3:0]  w_Raw, r_Sync1, r_Sync2, r_Deb, r_Paddle, w_Paddle_Next;
   logic [19:0] r_Count [4];
   state_t      r_State, w_State_Next;
   logic [1:0]  r_Sel, w_Sel_Next, r_Dir, w_Dir_Next;
   logic        r_Pulse, w_Pulse_Next;
   assign w_Raw = {bus.switch_rt, bus.switch_lt, bus.switch_dn, bus.switch_up};
   always_ff @(posedge i_Clk or posedge i_Rst)
      if (i_Rst) begin
         r_Sync1 <= '0;
         r_Sync2 <= '0;
         r_Deb   <= '0;
         for (int n = 0; n < 4; n++) r_Count[n] <= '0;
      end else begin
         r_Sync1 <= w_Raw;
         r_Sync2 <= r_Sync1;
         for (int n = 0; n < 4; n++)
            if (r_Sync2[n] == r_Deb[n]) r_Count[n] <= '0;
            else if (r_Count[n] == c_LAST) begin
               r_Deb[n]   <= ~r_Deb[n];
               r_Count[n] <= '0;
            end else r_Count[n] <= r_Count[n] + 20'd1;
      end
   always_ff @(posedge i_Clk or posedge i_Rst)
      if (i_Rst) begin
         r_State  <= IDLE;
         r_Sel    <= '0;
         r_Dir    <= '0;
         r_Paddle <= '0;
         r_Pulse  <= 1'b0;
      end else begin
         r_State  <= w_State_Next;
         r_Sel    <= w_Sel_Next;
         r_Dir    <= w_Dir_Next;
         r_Paddle <= w_Paddle_Next;
         r_Pulse  <= w_Pulse_Next;
      end
   // Outputs are decoded from the next state so they land in the same edge as the state change
   always_comb begin
      w_State_Next = r_State;
      w_Sel_Next   = r_Sel;
      w_Pulse_Next = 1'b0;
      if (r_State == IDLE && |r_Deb) begin
         w_State_Next = GRANT;
         w_Sel_Next   = r_Deb[0] ? 2'd0 : r_Deb[1] ? 2'd1 : r_Deb[2] ? 2'd2 : 2'd3;
         w_Pulse_Next = 1'b1;
      end else if (r_State == GRANT && !r_Deb[r_Sel])
         w_State_Next = |r_Deb ? WAIT_RELEASE : IDLE;
      else if (r_State == WAIT_RELEASE && !(|r_Deb))
         w_State_Next = IDLE;
      w_Dir_Next    = (w_State_Next == GRANT) ? w_Sel_Next : 2'd0;
      w_Paddle_Next = (w_State_Next == GRANT) ? 4'b0001 << w_Sel_Next : 4'd0;
   end
   assign bus.paddle_up   = r_Paddle[0];
   assign bus.paddle_dn   = r_Paddle[1];
   assign bus.paddle_lt   = r_Paddle[2];
   assign bus.paddle_rt   = r_Paddle[3];
   assign bus.dir         = r_Dir;
   assign bus.press_pulse = r_Pulse;
endmodule

// File: tb/tb_frogg_button_arbiter.sv
// tb_frogg_button_arbiter: directed and random checks of the button arbiter, debounce limit 4
module tb_frogg_button_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail = 0;
   int   pulses = 0;
   logic [3:0] paddles;
   frogg_button_arbiter_if bus();
   frogg_button_arbiter #(.c_DEBOUNCE_LIMIT(4)) dut (.i_Clk(clk), .i_Rst(rst), .bus(bus));
   always #5 clk = ~clk;
   assign paddles = {bus.paddle_rt, bus.paddle_lt, bus.paddle_dn, bus.paddle_up};
   always @(negedge clk) if (bus.press_pulse) pulses++;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_sw(input logic [3:0] v);
      {bus.switch_rt, bus.switch_lt, bus.switch_dn, bus.switch_up} = v;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      set_sw(4'b0000);
      tick(2);
      n_checks++;
      if ({paddles, bus.dir, bus.press_pulse} !== 7'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %b expected 0000000", {paddles, bus.dir, bus.press_pulse});
      end
      rst = 1'b0;
      tick(3);
      n_checks++;
      if ({paddles, bus.dir, bus.press_pulse} !== 7'd0) begin
         n_fail++;
         $display("FAIL post_reset_idle: got %b expected 0000000", {paddles, bus.dir, bus.press_pulse});
      end
   endtask

   task automatic test_up_latency;
      set_sw(4'b0001);
      tick(6);
      n_checks++;
      if (paddles !== 4'b0000) begin
         n_fail++;
         $display("FAIL up_early_edge6: got %b expected 0000", paddles);
      end
      tick(1);
      n_checks++;
      if ({paddles, bus.dir, bus.press_pulse} !== {4'b0001, 2'b00, 1'b1}) begin
         n_fail++;
         $display("FAIL up_grant_edge7: got %b expected 0001001", {paddles, bus.dir, bus.press_pulse});
      end
      tick(1);
      n_checks++;
      if ({paddles, bus.press_pulse} !== {4'b0001, 1'b0}) begin
         n_fail++;
         $display("FAIL up_pulse_end_edge8: got %b expected 00010", {paddles, bus.press_pulse});
      end
      set_sw(4'b0000);
      tick(6);
      n_checks++;
      if (paddles !== 4'b0001) begin
         n_fail++;
         $display("FAIL up_release_edge6: got %b expected 0001", paddles);
      end
      tick(1);
      n_checks++;
      if ({paddles, bus.dir} !== 6'd0) begin
         n_fail++;
         $display("FAIL up_release_edge7: got %b expected 000000", {paddles, bus.dir});
      end
      tick(3);
   endtask

   task automatic test_glitch;
      pulses = 0;
      set_sw(4'b1000);
      tick(3);
      set_sw(4'b0000);
      tick(10);
      n_checks++;
      if (paddles !== 4'b0000 || pulses !== 0) begin
         n_fail++;
         $display("FAIL glitch_3cyc: got paddles %b pulses %0d expected 0000 and 0", paddles, pulses);
      end
      set_sw(4'b1000);
      tick(4);
      set_sw(4'b0000);
      tick(3);
      n_checks++;
      if ({paddles, bus.dir} !== {4'b1000, 2'b11}) begin
         n_fail++;
         $display("FAIL min_press_4cyc: got %b expected 100011", {paddles, bus.dir});
      end
      tick(10);
      n_checks++;
      if (paddles !== 4'b0000 || pulses !== 1) begin
         n_fail++;
         $display("FAIL min_press_release: got paddles %b pulses %0d expected 0000 and 1", paddles, pulses);
      end
   endtask

   task automatic test_simultaneous;
      pulses = 0;
      set_sw(4'b0110);
      tick(7);
      n_checks++;
      if ({paddles, bus.dir} !== {4'b0010, 2'b01}) begin
         n_fail++;
         $display("FAIL simul_grant: got %b expected 001001", {paddles, bus.dir});
      end
      tick(5);
      n_checks++;
      if (paddles !== 4'b0010 || pulses !== 1) begin
         n_fail++;
         $display("FAIL simul_hold: got paddles %b pulses %0d expected 0010 and 1", paddles, pulses);
      end
      set_sw(4'b0000);
      tick(8);
      n_checks++;
      if (paddles !== 4'b0000) begin
         n_fail++;
         $display("FAIL simul_release: got %b expected 0000", paddles);
      end
   endtask

   task automatic test_takeover;
      pulses = 0;
      set_sw(4'b0100);
      tick(7);
      n_checks++;
      if ({paddles, bus.dir} !== {4'b0100, 2'b10}) begin
         n_fail++;
         $display("FAIL lt_grant: got %b expected 010010", {paddles, bus.dir});
      end
      tick(3);
      set_sw(4'b1100);
      tick(20);
      n_checks++;
      if ({paddles, bus.dir} !== {4'b0100, 2'b10} || pulses !== 1) begin
         n_fail++;
         $display("FAIL lt_held_rt_ignored: got %b pulses %0d expected 010010 and 1", {paddles, bus.dir}, pulses);
      end
      set_sw(4'b1000);
      tick(6);
      n_checks++;
      if (paddles !== 4'b0100) begin
         n_fail++;
         $display("FAIL lt_release_edge6: got %b expected 0100", paddles);
      end
      tick(1);
      n_checks++;
      if ({paddles, bus.dir} !== 6'd0) begin
         n_fail++;
         $display("FAIL wait_release_edge7: got %b expected 000000", {paddles, bus.dir});
      end
      tick(10);
      n_checks++;
      if (paddles !== 4'b0000 || pulses !== 1) begin
         n_fail++;
         $display("FAIL rt_no_takeover: got paddles %b pulses %0d expected 0000 and 1", paddles, pulses);
      end
      set_sw(4'b0000);
      tick(8);
      pulses = 0;
      set_sw(4'b1000);
      tick(7);
      n_checks++;
      if ({paddles, bus.dir, bus.press_pulse} !== {4'b1000, 2'b11, 1'b1}) begin
         n_fail++;
         $display("FAIL rt_repress_grant: got %b expected 1000111", {paddles, bus.dir, bus.press_pulse});
      end
      tick(3);
      n_checks++;
      if (pulses !== 1) begin
         n_fail++;
         $display("FAIL rt_repress_pulses: got %0d expected 1", pulses);
      end
      set_sw(4'b0000);
      tick(8);
   endtask

   task automatic test_reset_mid_grant;
      set_sw(4'b0001);
      tick(8);
      n_checks++;
      if (paddles !== 4'b0001) begin
         n_fail++;
         $display("FAIL pre_reset_grant: got %b expected 0001", paddles);
      end
      #3 rst = 1'b1;
      #1;
      n_checks++;
      if ({paddles, bus.dir, bus.press_pulse} !== 7'd0) begin
         n_fail++;
         $display("FAIL async_reset_clear: got %b expected 0000000", {paddles, bus.dir, bus.press_pulse});
      end
      @(posedge clk);
      @(posedge clk);
      #5 rst = 1'b0;
      tick(6);
      n_checks++;
      if (paddles !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_regrant_edge6: got %b expected 0000", paddles);
      end
      tick(1);
      n_checks++;
      if ({paddles, bus.press_pulse} !== {4'b0001, 1'b1}) begin
         n_fail++;
         $display("FAIL reset_regrant_edge7: got %b expected 00011", {paddles, bus.press_pulse});
      end
      set_sw(4'b0000);
      tick(8);
   endtask

   task automatic test_one_hot;
      logic [3:0] sw = 4'b0000;
      logic [1:0] exp_dir;
      for (int c = 0; c < 10000; c++) begin
         for (int b = 0; b < 4; b++) if ($urandom_range(15) == 0) sw[b] = ~sw[b];
         set_sw(sw);
         tick(1);
         exp_dir = paddles[3] ? 2'd3 : paddles[2] ? 2'd2 : paddles[1] ? 2'd1 : 2'd0;
         n_checks++;
         if ($countones(paddles) > 1 || bus.dir !== exp_dir || (bus.press_pulse && paddles == 4'b0000)) begin
            n_fail++;
            $display("FAIL one_hot cycle %0d: got paddles %b dir %b pulse %b expected one-hot dir %b",
                     c, paddles, bus.dir, bus.press_pulse, exp_dir);
         end
      end
      set_sw(4'b0000);
      tick(10);
   endtask

   initial begin
      set_sw(4'b0000);
      test_reset;
      test_up_latency;
      test_glitch;
      test_simultaneous;
      test_takeover;
      test_reset_mid_grant;
      test_one_hot;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
